// File: rtl/fir_stim_gen.sv
// rtl/fir_stim_gen.sv - FIR BIST stimulus generator and MISR response compactor (optional drain timeout: FIR_STIM_TIMEOUT_EN)
module fir_stim_gen #(
  parameter int         N_SAMPLES = 64,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         DRAIN_MAX = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic [7:0]  smp_out,
  output logic        smp_valid,
  input  logic        smp_ready,
  input  logic [7:0]  res_in,
  input  logic        res_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [7:0]  res_count,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  mode_q;
  logic [7:0]  idx;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_nxt;
  logic [15:0] misr_nxt;
  logic        start_take;
  logic        xfer;
  logic        last_xfer;
  logic        res_take;
  logic        drain_done;
  logic        drain_hit;

  // Every state change is qualified by ena so a low ena freezes the whole block.
  assign start_take = ena && (state == S_IDLE) && start;
  assign xfer       = ena && (state == S_RUN) && smp_ready;
  assign last_xfer  = xfer && (idx == 8'(N_SAMPLES - 1));
  assign res_take   = ena && res_valid && ((state == S_RUN) || (state == S_DRAIN));
  assign drain_done = int'(res_count) >= N_SAMPLES;

  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_nxt = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
                    ^ {8'h00, res_in};

  // Status outputs decode the state register so a reset clears them at once.
  assign smp_valid = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  // Pattern mux; index and LFSR only move on a transfer, so a stalled sample is stable.
  always_comb begin
    smp_out = 8'h00;
    if (state == S_RUN) begin
      case (mode_q)
        2'b00:   smp_out = (idx == 8'h00) ? 8'h7F : 8'h00;
        2'b01:   smp_out = 8'h40;
        2'b10:   smp_out = lfsr;
        default: smp_out = idx;
      endcase
    end
  end

`ifdef FIR_STIM_TIMEOUT_EN
  localparam int DCW = $clog2(DRAIN_MAX + 1);

  logic [DCW-1:0] drain_cnt;
  logic           timeout_q;

  // Timeout fires on the last idle DRAIN cycle unless results complete the run first.
  assign drain_hit = ena && (state == S_DRAIN) && !res_take && !drain_done
                     && (drain_cnt == DCW'(DRAIN_MAX - 1));
  assign timeout   = timeout_q;

  // Drain idle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else if (ena) begin
      if (start_take)
        timeout_q <= 1'b0;
      else if (drain_hit)
        timeout_q <= 1'b1;
      if (last_xfer || res_take)
        drain_cnt <= '0;
      else if (state == S_DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
    end
  end
`else
  // Without the timeout DRAIN only ends on results; this compare is constant 0.
  assign drain_hit = 1'b0;
  assign timeout   = (DRAIN_MAX < 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        S_IDLE:  if (start_take) state_nxt = S_RUN;
        S_RUN:   if (last_xfer) state_nxt = S_DRAIN;
        S_DRAIN: if (drain_done || drain_hit) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Run datapath: pattern state, MISR and saturating result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'b00;
      idx       <= 8'h00;
      lfsr      <= LFSR_SEED;
      signature <= 16'h0000;
      res_count <= 8'h00;
    end else if (ena) begin
      if (start_take) begin
        mode_q    <= mode;
        idx       <= 8'h00;
        lfsr      <= LFSR_SEED;
        signature <= 16'h0000;
        res_count <= 8'h00;
      end else begin
        if (xfer) begin
          idx  <= idx + 8'h01;
          lfsr <= lfsr_nxt;
        end
        if (res_take) begin
          signature <= misr_nxt;
          if (res_count != 8'hFF)
            res_count <= res_count + 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stim_gen.sv
// tb/tb_fir_stim_gen.sv - directed self-checking bench for fir_stim_gen
module tb_fir_stim_gen;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        smp_ready = 1'b0;
  logic [7:0]  res_in = 8'h00;
  logic        res_valid = 1'b0;
  logic [7:0]  smp_out;
  logic        smp_valid;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [7:0]  res_count;
  logic        timeout;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_sig;
  int          exp_cnt;
  int          n;
  logic [7:0]  s;

  fir_stim_gen #(.N_SAMPLES(N), .LFSR_SEED(8'hA5), .DRAIN_MAX(32)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode),
    .smp_out(smp_out), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .res_in(res_in), .res_valid(res_valid), .busy(busy), .done(done),
    .signature(signature), .res_count(res_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [15:0] misr_nx(input logic [15:0] g, input logic [7:0] r);
    return {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]} ^ {8'h00, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: transfers are scored at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (ena && smp_valid && smp_ready) begin
      if (exp_q.size() == 0)
        chk("xfer_unexpected", 32'(exp_q.size()), 32'd1);
      else
        chk("smp_out", 32'(smp_out), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic give_result(input logic [7:0] r);
    res_valid = 1'b1;
    res_in = r;
    exp_sig = misr_nx(exp_sig, r);
    exp_cnt++;
  endtask

  initial begin
    ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_smp_out", 32'(smp_out), 0);
    chk("rst_smp_valid", 32'(smp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_signature", 32'(signature), 0);
    chk("rst_res_count", 32'(res_count), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst_n = 1'b1;
    tick();

    // Impulse run with results during RUN and DRAIN.
    exp_sig = 16'h0000;
    exp_cnt = 0;
    exp_q.push_back(8'h7F);
    repeat (N - 1) exp_q.push_back(8'h00);
    smp_ready = 1'b1;
    mode = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("imp_valid_c1", 32'(smp_valid), 1);
    chk("imp_busy_c1", 32'(busy), 1);
    give_result(8'h01);
    tick();
    chk("sig_first", 32'(signature), 32'h0001);
    give_result(8'h01);
    tick();
    res_valid = 1'b0;
    chk("sig_second", 32'(signature), 32'h0003);
    chk("res_count_two", 32'(res_count), 2);
    tick();
    tick();
    chk("imp_valid_c5", 32'(smp_valid), 0);
    chk("imp_busy_drain", 32'(busy), 1);
    chk("imp_q_empty", 32'(exp_q.size()), 0);
    give_result(8'h10);
    tick();
    give_result(8'h20);
    tick();
    res_valid = 1'b0;
    chk("imp_count4", 32'(res_count), 4);
    chk("imp_done_early", 32'(done), 0);
    tick();
    chk("imp_done_pulse", 32'(done), 1);
    chk("imp_busy_in_done", 32'(busy), 0);
    chk("imp_signature", 32'(signature), 32'(exp_sig));
    tick();
    chk("imp_done_once", 32'(done), 0);
    res_valid = 1'b1;
    res_in = 8'hFF;
    tick();
    res_valid = 1'b0;
    chk("idle_res_sig", 32'(signature), 32'(exp_sig));
    chk("idle_res_cnt", 32'(res_count), 32'(exp_cnt));

    // LFSR run, 3 stalled cycles on the first sample, and a start while busy.
    s = 8'hA5;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(s);
      s = lfsr_nx(s);
    end
    exp_sig = 16'h0000;
    exp_cnt = 0;
    smp_ready = 1'b0;
    mode = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", 32'(smp_out), 32'hA5);
      chk("stall_valid", 32'(smp_valid), 1);
      if (i == 1) begin
        start = 1'b1;
        mode = 2'b11;
      end
      tick();
      start = 1'b0;
    end
    smp_ready = 1'b1;
    repeat (N) tick();
    chk("lfsr_q_empty", 32'(exp_q.size()), 0);
    chk("lfsr_sig_cleared", 32'(signature), 0);
    chk("lfsr_cnt_cleared", 32'(res_count), 0);
`ifdef FIR_STIM_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("drain_cycles", 32'(n), 32);
    chk("timeout_set", 32'(timeout), 1);
    chk("timeout_count", 32'(res_count), 0);
    tick();
`else
    repeat (40) tick();
    chk("drain_busy_hold", 32'(busy), 1);
    chk("no_timeout", 32'(timeout), 0);
    for (int i = 1; i <= N; i++) begin
      give_result(8'(i));
      tick();
    end
    res_valid = 1'b0;
    wait_done();
    chk("lfsr_signature", 32'(signature), 32'(exp_sig));
    tick();
`endif

    // Ramp run interrupted by reset.
    for (int i = 0; i < N; i++) exp_q.push_back(8'(i));
    mode = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(smp_valid), 0);
    chk("midrst_smp_out", 32'(smp_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_count", 32'(res_count), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_idle", 32'(busy), 0);
    chk("postrst_nodone", 32'(done), 0);

    // Step run with an ena freeze and results overlapping transfers.
    exp_sig = 16'h0000;
    exp_cnt = 0;
    repeat (N) exp_q.push_back(8'h40);
    mode = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    give_result(8'h33);
    tick();
    ena = 1'b0;
    res_in = 8'h99;
    repeat (3) begin
      chk("freeze_smp_out", 32'(smp_out), 32'h40);
      chk("freeze_count", 32'(res_count), 1);
      tick();
    end
    ena = 1'b1;
    give_result(8'h44);
    tick();
    give_result(8'h55);
    tick();
    give_result(8'h66);
    tick();
    res_valid = 1'b0;
    wait_done();
    chk("step_q_empty", 32'(exp_q.size()), 0);
    chk("step_signature", 32'(signature), 32'(exp_sig));
    chk("step_count", 32'(res_count), 32'(exp_cnt));
    chk("step_timeout", 32'(timeout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
